// File: rtl/biquad8_pkg.sv
// Shared format constants and saturation helpers for the biquad8 output stage.
package biquad8_pkg;

   localparam int DEF_NSAMP   = 8;
   localparam int DEF_INBITS  = 48;
   localparam int DEF_INFRAC  = 27;
   localparam int DEF_OUTBITS = 12;
   localparam int DEF_OUTFRAC = 0;
   localparam int DEF_CNTBITS = 16;
   localparam int LIM_W       = 64;

   // Full-width saturation limit for a two's-complement word of the given width;
   // callers keep the low <width> bits.
   function automatic logic [LIM_W-1:0] sat_limit(input int width, input logic neg);
      logic [LIM_W-1:0] one_v;
      one_v = {{(LIM_W-1){1'b0}}, 1'b1} << (width - 1);
      if (neg) begin
         sat_limit = ~one_v + 64'd1;
      end else begin
         sat_limit = one_v - 64'd1;
      end
   endfunction

endpackage

// File: rtl/biquad8_sat_lane.sv
// One output lane: round (stage 1), range-check and saturate (stage 2).
module biquad8_sat_lane
   import biquad8_pkg::*;
#(
   parameter int INBITS  = DEF_INBITS,
   parameter int INFRAC  = DEF_INFRAC,
   parameter int OUTBITS = DEF_OUTBITS,
   parameter int OUTFRAC = DEF_OUTFRAC,
   parameter int ROUND   = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INBITS-1:0]  dat_i,
   output logic [OUTBITS-1:0] dat_o,
   output logic               ovf_o
);

   localparam int SH   = INFRAC - OUTFRAC;
   localparam int EXTW = INBITS + 1;
   localparam int UPW  = EXTW - SH - OUTBITS;

   localparam logic [EXTW-1:0] RND_C = (ROUND == 1 && SH > 0) ?
      ({{(EXTW-1){1'b0}}, 1'b1} << ((SH > 0) ? (SH - 1) : 0)) : {EXTW{1'b0}};

   localparam logic [LIM_W-1:0] MAX_W = sat_limit(OUTBITS, 1'b0);
   localparam logic [LIM_W-1:0] MIN_W = sat_limit(OUTBITS, 1'b1);
   localparam logic [OUTBITS-1:0] MAX_C = MAX_W[OUTBITS-1:0];
   localparam logic [OUTBITS-1:0] MIN_C = MIN_W[OUTBITS-1:0];

   generate
      if (SH + OUTBITS > INBITS) begin : g_bad_width
         $error("biquad8_sat_lane: output window does not fit inside the input lane");
      end
   endgenerate

   logic [EXTW-1:0]    stage1_r;
   logic [OUTBITS-1:0] sat_s;
   logic               ovf_s;

   // The extension bit is the true sign; every bit above the output window must match the candidate MSB.
   function automatic logic [OUTBITS:0] range_sat(input logic [EXTW-1:0] v);
      logic [OUTBITS-1:0] cand_v;
      logic [UPW-1:0]     upper_v;
      cand_v  = v[SH +: OUTBITS];
      upper_v = v[EXTW-1 -: UPW];
      if (upper_v == {UPW{cand_v[OUTBITS-1]}}) begin
         range_sat = {1'b0, cand_v};
      end else if (v[EXTW-1]) begin
         range_sat = {1'b1, MIN_C};
      end else begin
         range_sat = {1'b1, MAX_C};
      end
   endfunction

   // Stage 1: sign-extend and add the rounding offset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage1_r <= {EXTW{1'b0}};
      end else begin
         stage1_r <= {dat_i[INBITS-1], dat_i} + RND_C;
      end
   end

   // Combinational saturation of the stage-1 value.
   always_comb begin
      {ovf_s, sat_s} = range_sat(stage1_r);
   end

   // Stage 2: register the saturated sample and its overflow event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dat_o <= {OUTBITS{1'b0}};
         ovf_o <= 1'b0;
      end else begin
         dat_o <= sat_s;
         ovf_o <= ovf_s;
      end
   end

endmodule

// File: rtl/biquad8_out_quantize.sv
// biquad8 output quantizer: per-lane round/saturate, 2-cycle pipeline,
// sticky per-lane overflow flags and a saturating overflow-cycle counter.
module biquad8_out_quantize
   import biquad8_pkg::*;
#(
   parameter int NSAMP   = DEF_NSAMP,
   parameter int INBITS  = DEF_INBITS,
   parameter int INFRAC  = DEF_INFRAC,
   parameter int OUTBITS = DEF_OUTBITS,
   parameter int OUTFRAC = DEF_OUTFRAC,
   parameter int ROUND   = 1,
   parameter int CNTBITS = DEF_CNTBITS
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [INBITS*NSAMP-1:0]  dat_i,
   input  logic                     dat_valid_i,
   output logic [OUTBITS*NSAMP-1:0] dat_o,
   output logic                     dat_valid_o,
   input  logic                     ovf_clr_i,
   output logic [NSAMP-1:0]         ovf_sticky_o,
   output logic [CNTBITS-1:0]       ovf_count_o
);

   localparam logic [CNTBITS-1:0] CNT_MAX_C = {CNTBITS{1'b1}};
   localparam logic [CNTBITS-1:0] CNT_ONE_C = {{(CNTBITS-1){1'b0}}, 1'b1};

   generate
      if (INFRAC < OUTFRAC) begin : g_bad_frac
         $error("biquad8_out_quantize: INFRAC must be >= OUTFRAC");
      end
   endgenerate

   logic [NSAMP-1:0]   lane_ovf_s;
   logic [NSAMP-1:0]   evt_s;
   logic               any_evt_s;
   logic               valid1_r;
   logic [CNTBITS-1:0] cnt_nxt_s;
   logic [NSAMP-1:0]   sticky_nxt_s;

   genvar k;
   generate
      for (k = 0; k < NSAMP; k++) begin : g_lane
         biquad8_sat_lane #(
            .INBITS  (INBITS),
            .INFRAC  (INFRAC),
            .OUTBITS (OUTBITS),
            .OUTFRAC (OUTFRAC),
            .ROUND   (ROUND)
         ) u_lane (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .dat_i (dat_i[k*INBITS +: INBITS]),
            .dat_o (dat_o[k*OUTBITS +: OUTBITS]),
            .ovf_o (lane_ovf_s[k])
         );
      end
   endgenerate

   // Valid bit travels alongside the two lane stages.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid1_r    <= 1'b0;
         dat_valid_o <= 1'b0;
      end else begin
         valid1_r    <= dat_valid_i;
         dat_valid_o <= valid1_r;
      end
   end

   // Next sticky/count values; a clear wipes history but still records this cycle's event.
   always_comb begin
      evt_s     = lane_ovf_s & {NSAMP{dat_valid_o}};
      any_evt_s = |evt_s;
      if (ovf_clr_i) begin
         sticky_nxt_s = evt_s;
         cnt_nxt_s    = any_evt_s ? CNT_ONE_C : {CNTBITS{1'b0}};
      end else begin
         sticky_nxt_s = ovf_sticky_o | evt_s;
         if (any_evt_s && (ovf_count_o != CNT_MAX_C)) begin
            cnt_nxt_s = ovf_count_o + CNT_ONE_C;
         end else begin
            cnt_nxt_s = ovf_count_o;
         end
      end
   end

   // Overflow status registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_sticky_o <= {NSAMP{1'b0}};
         ovf_count_o  <= {CNTBITS{1'b0}};
      end else begin
         ovf_sticky_o <= sticky_nxt_s;
         ovf_count_o  <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_biquad8_out_quantize.sv
// Scoreboard bench: two instances (rounding/16-bit counter and truncating/4-bit counter)
// share stimulus; expected samples are queued at issue and compared by a negedge monitor.
module tb_biquad8_out_quantize;

   localparam int NS = 8;
   localparam int IB = 48;
   localparam int OB = 12;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [IB*NS-1:0] dat_i;
   logic          dat_valid_i;
   logic          ovf_clr_i;
   logic [OB*NS-1:0] dat_o_a, dat_o_b;
   logic          vld_a, vld_b;
   logic [NS-1:0] st_a, st_b;
   logic [15:0]   cnt_a;
   logic [3:0]    cnt_b;

   always #5 clk = ~clk;

   biquad8_out_quantize dut_a (
      .clk_i (clk), .rst_i (rst_i), .dat_i (dat_i), .dat_valid_i (dat_valid_i),
      .dat_o (dat_o_a), .dat_valid_o (vld_a), .ovf_clr_i (ovf_clr_i),
      .ovf_sticky_o (st_a), .ovf_count_o (cnt_a)
   );

   biquad8_out_quantize #(.ROUND(0), .CNTBITS(4)) dut_b (
      .clk_i (clk), .rst_i (rst_i), .dat_i (dat_i), .dat_valid_i (dat_valid_i),
      .dat_o (dat_o_b), .dat_valid_o (vld_b), .ovf_clr_i (ovf_clr_i),
      .ovf_sticky_o (st_b), .ovf_count_o (cnt_b)
   );

   typedef struct {
      int             due;
      bit             valid;
      logic [OB*NS-1:0] exp_a;
      logic [NS-1:0]  ovf_a;
      logic [OB*NS-1:0] exp_b;
      logic [NS-1:0]  ovf_b;
   } item_t;

   item_t q[$];
   int    cyc = 0;
   int    errors = 0;
   int    checks = 0;
   bit    mon_en = 1'b0;

   // Reference status state.
   logic [NS-1:0] m_st_a = '0, m_st_b = '0;
   int            m_cnt_a = 0, m_cnt_b = 0;

   logic [IB-1:0] lanes [NS];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Real-valued meaning: input/2^27, round half up or floor, clamp to 12-bit range.
   function automatic void qmodel(input logic [IB-1:0] x, input bit rnd,
                                  output logic [OB-1:0] y, output bit ovf);
      longint v;
      v = longint'($signed(x));
      if (rnd) v = v + (longint'(1) <<< 26);
      v = v >>> 27;
      ovf = 1'b0;
      if (v > 2047) begin
         v = 2047; ovf = 1'b1;
      end else if (v < -2048) begin
         v = -2048; ovf = 1'b1;
      end
      y = v[OB-1:0];
   endfunction

   // Value in units of 0.5 as a 48-bit Q21.27 word.
   function automatic logic [IB-1:0] half(input longint n);
      longint t;
      t = n * (longint'(1) <<< 26);
      return t[IB-1:0];
   endfunction

   function automatic logic [IB-1:0] rand_lane();
      longint      t;
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0: t = $signed(r) >>> 26;
         1: t = $signed(r) >>> 24;
         2: t = (($urandom_range(0, 1) == 1) ? longint'(2047) : longint'(-2048)) * (longint'(1) <<< 27)
                + longint'($urandom_range(0, 2 ** 28)) - (longint'(1) <<< 27);
         default: t = $signed(r);
      endcase
      return t[IB-1:0];
   endfunction

   task automatic clear_lanes();
      for (int i = 0; i < NS; i++) lanes[i] = '0;
   endtask

   task automatic issue(input bit vld, input bit clr, input bit rst);
      item_t         it;
      logic [OB-1:0] y;
      bit            o;
      for (int i = 0; i < NS; i++) begin
         dat_i[i*IB +: IB] = lanes[i];
         qmodel(lanes[i], 1'b1, y, o);
         it.exp_a[i*OB +: OB] = y;
         it.ovf_a[i] = o;
         qmodel(lanes[i], 1'b0, y, o);
         it.exp_b[i*OB +: OB] = y;
         it.ovf_b[i] = o;
      end
      dat_valid_i = vld;
      ovf_clr_i   = clr;
      rst_i       = rst;
      if (!rst) begin
         it.due   = cyc + 2;
         it.valid = vld;
         q.push_back(it);
      end
      @(posedge clk);
      #1;
      if (rst) q.delete();
   endtask

   // Monitor: compare due samples and status against the reference, then advance the reference.
   always @(negedge clk) begin : mon
      item_t         it;
      logic [NS-1:0] ev_a, ev_b;
      if (mon_en) begin
         ev_a = '0;
         ev_b = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            it = q.pop_front();
            chk("dat_o_a", dat_o_a, it.exp_a);
            chk("dat_o_b", dat_o_b, it.exp_b);
            chk("dat_valid_o_a", vld_a, it.valid);
            chk("dat_valid_o_b", vld_b, it.valid);
            if (it.valid) begin
               ev_a = it.ovf_a;
               ev_b = it.ovf_b;
            end
         end else begin
            chk("idle_valid_a", vld_a, 1'b0);
            chk("idle_valid_b", vld_b, 1'b0);
         end
         chk("sticky_a", st_a, m_st_a);
         chk("sticky_b", st_b, m_st_b);
         chk("count_a", cnt_a, m_cnt_a[15:0]);
         chk("count_b", cnt_b, m_cnt_b[3:0]);
         if (rst_i) begin
            m_st_a = '0; m_st_b = '0; m_cnt_a = 0; m_cnt_b = 0;
         end else if (ovf_clr_i) begin
            m_st_a = ev_a; m_st_b = ev_b;
            m_cnt_a = (ev_a != 0) ? 1 : 0;
            m_cnt_b = (ev_b != 0) ? 1 : 0;
         end else begin
            m_st_a = m_st_a | ev_a;
            m_st_b = m_st_b | ev_b;
            if (ev_a != 0 && m_cnt_a < 65535) m_cnt_a++;
            if (ev_b != 0 && m_cnt_b < 15) m_cnt_b++;
         end
      end
   end

   initial begin
      rst_i = 1'b1; dat_i = '0; dat_valid_i = 1'b0; ovf_clr_i = 1'b0;
      clear_lanes();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_dat_o_a", dat_o_a, '0);
      chk("reset_dat_o_b", dat_o_b, '0);
      chk("reset_valid_a", vld_a, 1'b0);
      chk("reset_sticky_a", st_a, '0);
      chk("reset_count_a", cnt_a, '0);
      chk("reset_count_b", cnt_b, '0);
      mon_en = 1'b1;
      rst_i  = 1'b0;

      // Rounding: 1.5, 2.5, -1.5, just below 1.0
      lanes[0] = half(3); lanes[1] = half(5); lanes[2] = half(-3); lanes[3] = 48'h0000_07FF_FFFF;
      issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      issue(1'b0, 1'b0, 1'b0);
      // Saturation on lanes 5 and 6
      lanes[5] = half(6000); lanes[6] = half(-6000);
      issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      // Rounding-induced overflow and its negative non-overflow twin
      lanes[0] = half(4095);
      issue(1'b1, 1'b0, 1'b0);
      lanes[0] = half(-4097);
      issue(1'b1, 1'b0, 1'b0);
      // Overflowing data without valid: saturated output, no status change
      clear_lanes();
      lanes[1] = half(10000);
      issue(1'b0, 1'b0, 1'b0);
      clear_lanes();
      repeat (3) issue(1'b0, 1'b0, 1'b0);

      // Randomized traffic with occasional clears
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NS; i++) lanes[i] = rand_lane();
         issue($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0);
      end

      // Counter saturation: 20 consecutive overflowing valid cycles
      clear_lanes();
      lanes[5] = half(-8000);
      repeat (20) issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      // Lane 2 event qualified in the same cycle as the clear
      lanes[3] = half(7000);
      issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      lanes[2] = half(6000);
      issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      issue(1'b0, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 1'b0);
      repeat (3) issue(1'b0, 1'b0, 1'b0);

      // Reset with a full valid pipeline, then restart
      lanes[4] = half(9000);
      repeat (3) issue(1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 1'b1);
      chk("midreset_dat_o_a", dat_o_a, '0);
      chk("midreset_dat_o_b", dat_o_b, '0);
      chk("midreset_valid_a", vld_a, 1'b0);
      chk("midreset_sticky_a", st_a, '0);
      chk("midreset_count_b", cnt_b, '0);
      lanes[4] = half(-9000);
      repeat (3) issue(1'b1, 1'b0, 1'b0);
      clear_lanes();
      repeat (4) issue(1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
